// File: rtl/decode_stage_param.sv
// ID stage: instruction decode, integer register file, immediate sign-extension and ID/EX pipeline register.
// Optional DECODE_BYPASS_EN: register-file write-through of same-cycle writeback data to the read ports.
module decode_stage_param #(
  parameter int INSTR_W    = 20,
  parameter int DATA_W     = 19,
  parameter int PC_W       = 15,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 19,
  parameter int OP_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INSTR_W-1:0]    InstrD,
  input  logic [PC_W-1:0]       PCD,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [DATA_W-1:0]     ResultW,
  input  logic                  StallE,
  input  logic                  FlushE,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic [1:0]            ResultSrcE,
  output logic [2:0]            ALUControlE,
  output logic [DATA_W-1:0]     RD1E,
  output logic [DATA_W-1:0]     RD2E,
  output logic [DATA_W-1:0]     ImmExtE,
  output logic [PC_W-1:0]       PCE,
  output logic [REG_ADDR_W-1:0] RS1E,
  output logic [REG_ADDR_W-1:0] RS2E,
  output logic [REG_ADDR_W-1:0] RDE,
  output logic                  ValidE,
  output logic                  IllegalE
);

  localparam int OB     = OP_W + 2*REG_ADDR_W;
  localparam int IMMI_W = INSTR_W - OB;
  localparam int IMMJ_W = INSTR_W - OP_W;

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(8);

  logic [OP_W-1:0]       op;
  logic [REG_ADDR_W-1:0] f1, f2, f3;
  logic [IMMI_W-1:0]     imm_i;
  logic [IMMJ_W-1:0]     imm_j;
  logic [DATA_W-1:0]     imm_i_ext, imm_j_ext;

  assign op    = InstrD[OP_W-1:0];
  assign f1    = InstrD[OP_W+REG_ADDR_W-1:OP_W];
  assign f2    = InstrD[OP_W+2*REG_ADDR_W-1:OP_W+REG_ADDR_W];
  assign f3    = InstrD[OP_W+3*REG_ADDR_W-1:OP_W+2*REG_ADDR_W];
  assign imm_i = InstrD[INSTR_W-1:OB];
  assign imm_j = InstrD[INSTR_W-1:OP_W];
  assign imm_i_ext = {{(DATA_W-IMMI_W){imm_i[IMMI_W-1]}}, imm_i};
  assign imm_j_ext = {{(DATA_W-IMMJ_W){imm_j[IMMJ_W-1]}}, imm_j};

  logic                  reg_write, mem_write, jump, branch, alu_src, illegal;
  logic [1:0]            result_src;
  logic [2:0]            alu_control;
  logic [DATA_W-1:0]     imm_ext;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;

  always_comb begin
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    alu_src     = 1'b0;
    illegal     = 1'b0;
    result_src  = 2'b00;
    alu_control = 3'b000;
    imm_ext     = '0;
    rs1         = '0;
    rs2         = '0;
    rd          = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        rd          = f1;
        rs1         = f2;
        rs2         = f3;
        reg_write   = 1'b1;
        alu_control = op[2:0];
      end
      OP_ADDI, OP_LOAD: begin
        rd         = f1;
        rs1        = f2;
        alu_src    = 1'b1;
        reg_write  = 1'b1;
        imm_ext    = imm_i_ext;
        result_src = (op == OP_LOAD) ? 2'b01 : 2'b00;
      end
      OP_STORE: begin
        rs2       = f1;
        rs1       = f2;
        alu_src   = 1'b1;
        mem_write = 1'b1;
        imm_ext   = imm_i_ext;
      end
      OP_BEQ: begin
        rs1         = f1;
        rs2         = f2;
        branch      = 1'b1;
        alu_control = 3'b001;
        imm_ext     = imm_i_ext;
      end
      OP_JMP: begin
        jump       = 1'b1;
        result_src = 2'b10;
        imm_ext    = imm_j_ext;
      end
      default: illegal = 1'b1;
    endcase
  end

  // r0 is never written, so it stays zero after reset
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok, rs1_ok, rs2_ok;
  logic [DATA_W-1:0] rd1, rd2;

  assign wr_ok  = RegWriteW && (RdW != '0) && (32'(RdW) < NUM_REGS);
  assign rs1_ok = (rs1 != '0) && (32'(rs1) < NUM_REGS);
  assign rs2_ok = (rs2 != '0) && (32'(rs2) < NUM_REGS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[RdW] <= ResultW;
    end
  end

  always_comb begin
    rd1 = rs1_ok ? regs[rs1] : '0;
    rd2 = rs2_ok ? regs[rs2] : '0;
`ifdef DECODE_BYPASS_EN
    if (wr_ok && (RdW == rs1)) rd1 = ResultW;
    if (wr_ok && (RdW == rs2)) rd2 = ResultW;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || FlushE) begin
      if (!reset || FlushE) begin end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, IllegalE} <= '0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      RS1E        <= '0;
      RS2E        <= '0;
      RDE         <= '0;
    end else if (FlushE) begin
      {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, IllegalE} <= '0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      RS1E        <= '0;
      RS2E        <= '0;
      RDE         <= '0;
    end else if (!StallE) begin
      RegWriteE   <= reg_write;
      MemWriteE   <= mem_write;
      JumpE       <= jump;
      BranchE     <= branch;
      ALUSrcE     <= alu_src;
      ValidE      <= 1'b1;
      IllegalE    <= illegal;
      ResultSrcE  <= result_src;
      ALUControlE <= alu_control;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
      PCE         <= PCD;
      RS1E        <= rs1;
      RS2E        <= rs2;
      RDE         <= rd;
    end
  end

endmodule

// File: tb/tb_decode_stage_param.sv
// Self-checking bench for decode_stage_param: vector table plus stall/flush/bypass/reset sequences.
// Expected results are queued when stimulus is driven and compared after the capturing edge.
module tb_decode_stage_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] InstrD;
  logic [14:0] PCD;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [18:0] ResultW;
  logic        StallE, FlushE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [18:0] RD1E, RD2E, ImmExtE;
  logic [14:0] PCE;
  logic [4:0]  RS1E, RS2E, RDE;

  decode_stage_param dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .StallE(StallE), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE), .ValidE(ValidE), .IllegalE(IllegalE)
  );

  always #5 clk = ~clk;

`ifdef DECODE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct packed {
    logic rw, mw, j, b, as;
    logic [1:0]  rs;
    logic [2:0]  alu;
    logic [18:0] rd1, rd2, imm;
    logic [14:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        valid, ill;
  } exp_t;

  typedef struct {
    logic [19:0] instr;
    logic [14:0] pc;
    logic        rw;
    logic [4:0]  rdw;
    logic [18:0] res;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  function automatic exp_t mk(logic rw, logic mw, logic j, logic b, logic as, logic [1:0] rs,
                              logic [2:0] alu, logic [18:0] rd1, logic [18:0] rd2, logic [18:0] imm,
                              logic [14:0] pc, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic ill);
    return '{rw, mw, j, b, as, rs, alu, rd1, rd2, imm, pc, rs1, rs2, rd, 1'b1, ill};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic cmp_out(string tag, exp_t e);
    chk({tag, ".RegWriteE"},   32'(RegWriteE),   32'(e.rw));
    chk({tag, ".MemWriteE"},   32'(MemWriteE),   32'(e.mw));
    chk({tag, ".JumpE"},       32'(JumpE),       32'(e.j));
    chk({tag, ".BranchE"},     32'(BranchE),     32'(e.b));
    chk({tag, ".ALUSrcE"},     32'(ALUSrcE),     32'(e.as));
    chk({tag, ".ResultSrcE"},  32'(ResultSrcE),  32'(e.rs));
    chk({tag, ".ALUControlE"}, 32'(ALUControlE), 32'(e.alu));
    chk({tag, ".RD1E"},        32'(RD1E),        32'(e.rd1));
    chk({tag, ".RD2E"},        32'(RD2E),        32'(e.rd2));
    chk({tag, ".ImmExtE"},     32'(ImmExtE),     32'(e.imm));
    chk({tag, ".PCE"},         32'(PCE),         32'(e.pc));
    chk({tag, ".RS1E"},        32'(RS1E),        32'(e.rs1));
    chk({tag, ".RS2E"},        32'(RS2E),        32'(e.rs2));
    chk({tag, ".RDE"},         32'(RDE),         32'(e.rd));
    chk({tag, ".ValidE"},      32'(ValidE),      32'(e.valid));
    chk({tag, ".IllegalE"},    32'(IllegalE),    32'(e.ill));
  endtask

  task automatic step(string tag, logic [19:0] instr, logic [14:0] pc, logic rw, logic [4:0] rdw,
                      logic [18:0] res, logic stall, logic flush, exp_t e);
    @(negedge clk);
    InstrD = instr; PCD = pc; RegWriteW = rw; RdW = rdw; ResultW = res;
    StallE = stall; FlushE = flush;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty, got 0 entries expected 1", tag);
    end else begin
      cmp_out(tag, sb.pop_front());
    end
  endtask

  vec_t tbl[13];
  exp_t e_a, e_byp;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{20'h14034, 15'h100, 1'b1, 5'd2,  19'h12345, mk(1,0,0,0,1,2'd0,3'd0, 19'h0, 19'h0, 19'h5, 15'h100, 5'd0, 5'd0, 5'd3, 0)};
    tbl[1]  = '{20'hFC034, 15'h101, 1'b1, 5'd0,  19'h00007, mk(1,0,0,0,1,2'd0,3'd0, 19'h0, 19'h0, 19'h7FFFF, 15'h101, 5'd0, 5'd0, 5'd3, 0)};
    tbl[2]  = '{20'h08410, 15'h102, 1'b0, 5'd0,  19'h0,     mk(1,0,0,0,0,2'd0,3'd0, 19'h12345, 19'h12345, 19'h0, 15'h102, 5'd2, 5'd2, 5'd1, 0)};
    tbl[3]  = '{20'h00010, 15'h103, 1'b0, 5'd0,  19'h0,     mk(1,0,0,0,0,2'd0,3'd0, 19'h0, 19'h0, 19'h0, 15'h103, 5'd0, 5'd0, 5'd1, 0)};
    tbl[4]  = '{20'hFFFF8, 15'h104, 1'b0, 5'd0,  19'h0,     mk(0,0,1,0,0,2'd2,3'd0, 19'h0, 19'h0, 19'h7FFFF, 15'h104, 5'd0, 5'd0, 5'd0, 0)};
    tbl[5]  = '{20'h0000F, 15'h105, 1'b0, 5'd0,  19'h0,     mk(0,0,0,0,0,2'd0,3'd0, 19'h0, 19'h0, 19'h0, 15'h105, 5'd0, 5'd0, 5'd0, 1)};
    tbl[6]  = '{20'h08411, 15'h106, 1'b0, 5'd0,  19'h0,     mk(1,0,0,0,0,2'd0,3'd1, 19'h12345, 19'h12345, 19'h0, 15'h106, 5'd2, 5'd2, 5'd1, 0)};
    tbl[7]  = '{20'h0C026, 15'h107, 1'b0, 5'd0,  19'h0,     mk(0,1,0,0,1,2'd0,3'd0, 19'h0, 19'h12345, 19'h3, 15'h107, 5'd0, 5'd2, 5'd0, 0)};
    tbl[8]  = '{20'hF8027, 15'h108, 1'b0, 5'd0,  19'h0,     mk(0,0,0,1,0,2'd0,3'd1, 19'h12345, 19'h0, 19'h7FFFE, 15'h108, 5'd2, 5'd0, 5'd0, 0)};
    tbl[9]  = '{20'h04465, 15'h109, 1'b0, 5'd0,  19'h0,     mk(1,0,0,0,1,2'd1,3'd0, 19'h12345, 19'h0, 19'h1, 15'h109, 5'd2, 5'd0, 5'd6, 0)};
    tbl[10] = '{20'h00473, 15'h10A, 1'b0, 5'd0,  19'h0,     mk(1,0,0,0,0,2'd0,3'd3, 19'h12345, 19'h0, 19'h0, 15'h10A, 5'd2, 5'd0, 5'd7, 0)};
    tbl[11] = '{20'h0A810, 15'h10B, 1'b1, 5'd20, 19'h01111, mk(1,0,0,0,0,2'd0,3'd0, 19'h0, 19'h12345, 19'h0, 15'h10B, 5'd20, 5'd2, 5'd1, 0)};
    tbl[12] = '{20'h08412, 15'h10C, 1'b0, 5'd0,  19'h0,     mk(1,0,0,0,0,2'd0,3'd2, 19'h12345, 19'h12345, 19'h0, 15'h10C, 5'd2, 5'd2, 5'd1, 0)};

    reset = 1'b0; InstrD = 20'h14034; PCD = 15'h7; RegWriteW = 1'b1; RdW = 5'd3;
    ResultW = 19'h1; StallE = 1'b0; FlushE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_out("reset_hold", '0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 13; i++)
      step($sformatf("vec%0d", i), tbl[i].instr, tbl[i].pc, tbl[i].rw, tbl[i].rdw, tbl[i].res,
           1'b0, 1'b0, tbl[i].e);

    // same-cycle writeback of r4 while reading it
    e_byp = mk(1,0,0,0,0,2'd0,3'd0, BYP ? 19'h00AAA : 19'h0, BYP ? 19'h00AAA : 19'h0, 19'h0,
               15'h150, 5'd4, 5'd4, 5'd1, 0);
    step("bypass_same", 20'h10810, 15'h150, 1'b1, 5'd4, 19'h00AAA, 1'b0, 1'b0, e_byp);
    step("bypass_next", 20'h10810, 15'h151, 1'b0, 5'd0, 19'h0, 1'b0, 1'b0,
         mk(1,0,0,0,0,2'd0,3'd0, 19'h00AAA, 19'h00AAA, 19'h0, 15'h151, 5'd4, 5'd4, 5'd1, 0));

    e_a = mk(1,0,0,0,0,2'd0,3'd0, 19'h12345, 19'h12345, 19'h0, 15'h200, 5'd2, 5'd2, 5'd1, 0);
    step("stall_cap",   20'h08410, 15'h200, 1'b0, 5'd0, 19'h0, 1'b0, 1'b0, e_a);
    step("stall_1",     20'h14034, 15'h201, 1'b0, 5'd0, 19'h0, 1'b1, 1'b0, e_a);
    step("stall_2",     20'hFFFF8, 15'h202, 1'b0, 5'd0, 19'h0, 1'b1, 1'b0, e_a);
    step("stall_flush", 20'h0000F, 15'h203, 1'b0, 5'd0, 19'h0, 1'b1, 1'b1, '0);
    e_a.pc = 15'h204;
    step("after_flush", 20'h08410, 15'h204, 1'b0, 5'd0, 19'h0, 1'b0, 1'b0, e_a);

    step("wr_r5",   20'h0000F, 15'h300, 1'b1, 5'd5, 19'h00555, 1'b0, 1'b0,
         mk(0,0,0,0,0,2'd0,3'd0, 19'h0, 19'h0, 19'h0, 15'h300, 5'd0, 5'd0, 5'd0, 1));
    step("rd_r5",   20'h00A10, 15'h301, 1'b0, 5'd0, 19'h0, 1'b0, 1'b0,
         mk(1,0,0,0,0,2'd0,3'd0, 19'h00555, 19'h0, 19'h0, 15'h301, 5'd5, 5'd0, 5'd1, 0));
    #3;
    reset = 1'b0;
    #1;
    cmp_out("async_reset", '0);
    @(negedge clk);
    reset = 1'b1;
    step("rd_r5_post_reset", 20'h00A10, 15'h302, 1'b0, 5'd0, 19'h0, 1'b0, 1'b0,
         mk(1,0,0,0,0,2'd0,3'd0, 19'h0, 19'h0, 19'h0, 15'h302, 5'd5, 5'd0, 5'd1, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
